// File: rtl/key_bank_pkg.sv
// Shared types and helpers for the key_bank key store.
// Covers the state encoding, index-width sizing and slot bit-offset math.
package key_bank_pkg;

    typedef enum logic [0:0] {
        LOAD   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Index width that never collapses to zero bits for a single-slot bank.
    function automatic int clog2_min1(input int n);
        int r;
        if (n <= 1) begin
            r = 1;
        end else begin
            r = $clog2(n);
        end
        return r;
    endfunction

    function automatic int slot_lo(input int idx, input int key_w);
        return idx * key_w;
    endfunction

endpackage

// File: rtl/key_match.sv
// Registered lookup: compares a query against every committed slot and
// reports the lowest matching slot one cycle after the request.
module key_match
    import key_bank_pkg::*;
#(
    parameter int KEY_W    = 8,
    parameter int MAX_KEYS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              q_valid,
    input  logic [KEY_W-1:0]                  q_data,
    input  logic [MAX_KEYS*KEY_W-1:0]         keys,
    input  logic [MAX_KEYS-1:0]               keys_valid,
    output logic                              hit,
    output logic [clog2_min1(MAX_KEYS)-1:0]   hit_idx,
    output logic                              hit_vld
);

    localparam int IDX_W = clog2_min1(MAX_KEYS);

    logic             hit_d,  hit_q;
    logic [IDX_W-1:0] idx_d,  idx_q;
    logic             vld_d,  vld_q;

    // Priority encode: scanning from the top lets the lowest match win.
    always_comb begin
        hit_d = 1'b0;
        idx_d = {IDX_W{1'b0}};
        vld_d = q_valid;
        if (q_valid) begin
            for (int i = MAX_KEYS - 1; i >= 0; i--) begin
                if (keys_valid[i] && (keys[slot_lo(i, KEY_W) +: KEY_W] == q_data)) begin
                    hit_d = 1'b1;
                    idx_d = IDX_W'(i);
                end else begin
                    hit_d = hit_d;
                end
            end
        end else begin
            hit_d = 1'b0;
        end
    end

    // Result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q <= 1'b0;
            idx_q <= {IDX_W{1'b0}};
            vld_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
            idx_q <= idx_d;
            vld_q <= vld_d;
        end
    end

    assign hit     = hit_q;
    assign hit_idx = idx_q;
    assign hit_vld = vld_q;

endmodule

// File: rtl/key_bank.sv
// Key store: staged writes, atomic commit to a published key set, and a
// registered lookup port against the published set.
module key_bank
    import key_bank_pkg::*;
#(
    parameter int KEY_W    = 8,
    parameter int MAX_KEYS = 4,
    parameter int WRAP     = 0,
    parameter int CNT_W    = $clog2(MAX_KEYS + 1)
) (
    input  logic                              dclk,
    input  logic                              reset,
    input  logic [KEY_W-1:0]                  din,
    input  logic                              wr_en,
    input  logic                              kset,
    input  logic                              clr,
    input  logic                              q_valid,
    input  logic [KEY_W-1:0]                  q_data,
    output logic [CNT_W-1:0]                  num_keys,
    output logic [MAX_KEYS*KEY_W-1:0]         keys,
    output logic [MAX_KEYS-1:0]               keys_valid,
    output logic                              locked,
    output logic                              ovf,
    output logic                              hit,
    output logic [clog2_min1(MAX_KEYS)-1:0]   hit_idx,
    output logic                              hit_vld
);

    localparam int PTR_W = clog2_min1(MAX_KEYS);
    localparam int BANK_W = MAX_KEYS * KEY_W;

    state_e              state_d,      state_q;
    logic [BANK_W-1:0]   staging_d,    staging_q;
    logic [PTR_W-1:0]    wr_ptr_d,     wr_ptr_q;
    logic [CNT_W-1:0]    num_keys_d,   num_keys_q;
    logic                ovf_d,        ovf_q;
    logic [BANK_W-1:0]   keys_d,       keys_q;
    logic [MAX_KEYS-1:0] keys_valid_d, keys_valid_q;

    logic                full;
    logic [PTR_W-1:0]    ptr_inc;

    assign full    = (num_keys_q == CNT_W'(MAX_KEYS));
    assign ptr_inc = (wr_ptr_q == PTR_W'(MAX_KEYS - 1)) ? {PTR_W{1'b0}}
                                                        : (wr_ptr_q + PTR_W'(1));

    // Next-state: clr wins; commit sees the same-cycle write via the _d values.
    always_comb begin
        state_d      = state_q;
        staging_d    = staging_q;
        wr_ptr_d     = wr_ptr_q;
        num_keys_d   = num_keys_q;
        ovf_d        = ovf_q;
        keys_d       = keys_q;
        keys_valid_d = keys_valid_q;

        if (clr) begin
            staging_d  = {BANK_W{1'b0}};
            wr_ptr_d   = {PTR_W{1'b0}};
            num_keys_d = {CNT_W{1'b0}};
            ovf_d      = 1'b0;
            state_d    = LOAD;
        end else begin
            case (state_q)
                LOAD: begin
                    if (wr_en) begin
                        if (!full || (WRAP != 0)) begin
                            for (int i = 0; i < MAX_KEYS; i++) begin
                                if (wr_ptr_q == PTR_W'(i)) begin
                                    staging_d[slot_lo(i, KEY_W) +: KEY_W] = din;
                                end else begin
                                    staging_d[slot_lo(i, KEY_W) +: KEY_W] =
                                        staging_q[slot_lo(i, KEY_W) +: KEY_W];
                                end
                            end
                            wr_ptr_d = ptr_inc;
                        end else begin
                            wr_ptr_d = wr_ptr_q;
                        end
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            num_keys_d = num_keys_q + CNT_W'(1);
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                    end

                    if (kset && (num_keys_d != {CNT_W{1'b0}})) begin
                        keys_d = staging_d;
                        for (int i = 0; i < MAX_KEYS; i++) begin
                            keys_valid_d[i] = (CNT_W'(i) < num_keys_d);
                        end
                        state_d = LOCKED;
                    end else begin
                        state_d = LOAD;
                    end
                end
                LOCKED: begin
                    state_d = LOCKED;
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge dclk) begin
        if (reset) begin
            state_q      <= LOAD;
            staging_q    <= {BANK_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            num_keys_q   <= {CNT_W{1'b0}};
            ovf_q        <= 1'b0;
            keys_q       <= {BANK_W{1'b0}};
            keys_valid_q <= {MAX_KEYS{1'b0}};
        end else begin
            state_q      <= state_d;
            staging_q    <= staging_d;
            wr_ptr_q     <= wr_ptr_d;
            num_keys_q   <= num_keys_d;
            ovf_q        <= ovf_d;
            keys_q       <= keys_d;
            keys_valid_q <= keys_valid_d;
        end
    end

    // Lookup sees keys_q, so a same-cycle commit is not yet visible to it.
    key_match #(
        .KEY_W    (KEY_W),
        .MAX_KEYS (MAX_KEYS)
    ) u_match (
        .clk        (dclk),
        .reset      (reset),
        .q_valid    (q_valid),
        .q_data     (q_data),
        .keys       (keys_q),
        .keys_valid (keys_valid_q),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .hit_vld    (hit_vld)
    );

    assign num_keys   = num_keys_q;
    assign keys       = keys_q;
    assign keys_valid = keys_valid_q;
    assign locked     = (state_q == LOCKED);
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_key_bank.sv
// Bench for key_bank: three configurations driven in lockstep and compared
// every cycle against a behavioural model, plus literal spot checks.
module tb_key_bank;

    logic        dclk = 1'b0;
    logic        reset, wr_en, kset, clr, q_valid;
    logic [15:0] din, q_data;

    always #5 dclk = ~dclk;

    logic [2:0]   num0, num1;
    logic [3:0]   num2;
    logic [31:0]  keys0, keys1;
    logic [127:0] keys2;
    logic [3:0]   kv0, kv1;
    logic [7:0]   kv2;
    logic         lk0, lk1, lk2, ov0, ov1, ov2;
    logic         hit0, hit1, hit2, hv0, hv1, hv2;
    logic [1:0]   hidx0, hidx1;
    logic [2:0]   hidx2;

    key_bank #(.KEY_W(8), .MAX_KEYS(4), .WRAP(0)) u0 (
        .dclk(dclk), .reset(reset), .din(din[7:0]), .wr_en(wr_en), .kset(kset),
        .clr(clr), .q_valid(q_valid), .q_data(q_data[7:0]), .num_keys(num0),
        .keys(keys0), .keys_valid(kv0), .locked(lk0), .ovf(ov0), .hit(hit0),
        .hit_idx(hidx0), .hit_vld(hv0));

    key_bank #(.KEY_W(8), .MAX_KEYS(4), .WRAP(1)) u1 (
        .dclk(dclk), .reset(reset), .din(din[7:0]), .wr_en(wr_en), .kset(kset),
        .clr(clr), .q_valid(q_valid), .q_data(q_data[7:0]), .num_keys(num1),
        .keys(keys1), .keys_valid(kv1), .locked(lk1), .ovf(ov1), .hit(hit1),
        .hit_idx(hidx1), .hit_vld(hv1));

    key_bank #(.KEY_W(16), .MAX_KEYS(8), .WRAP(1)) u2 (
        .dclk(dclk), .reset(reset), .din(din), .wr_en(wr_en), .kset(kset),
        .clr(clr), .q_valid(q_valid), .q_data(q_data), .num_keys(num2),
        .keys(keys2), .keys_valid(kv2), .locked(lk2), .ovf(ov2), .hit(hit2),
        .hit_idx(hidx2), .hit_vld(hv2));

    // Model configuration per instance.
    int kw [3] = '{8, 8, 16};
    int mk [3] = '{4, 4, 8};
    int wp [3] = '{0, 1, 1};

    // Model state: nw counts accepted writes, so the slot is nw % mk.
    logic [15:0] stg [3][8];
    logic [15:0] key [3][8];
    bit          kv  [3][8];
    int          nw  [3];
    bit          mlk [3], mov [3], ehv [3], ehit [3];
    int          eidx [3];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input int k, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h, expected %0h", nm, k, act, exp);
        end
    endtask

    task automatic model_step();
        logic [15:0] m;
        int cnt;
        bit full;
        for (int k = 0; k < 3; k++) begin
            m = (kw[k] == 16) ? 16'hFFFF : 16'h00FF;
            if (reset) begin
                for (int i = 0; i < 8; i++) begin
                    stg[k][i] = 16'h0000; key[k][i] = 16'h0000; kv[k][i] = 1'b0;
                end
                nw[k] = 0; mlk[k] = 1'b0; mov[k] = 1'b0;
                ehv[k] = 1'b0; ehit[k] = 1'b0; eidx[k] = 0;
            end else begin
                ehv[k] = q_valid; ehit[k] = 1'b0; eidx[k] = 0;
                if (q_valid) begin
                    for (int i = 0; i < mk[k]; i++) begin
                        if (!ehit[k] && kv[k][i] && key[k][i] == (q_data & m)) begin
                            ehit[k] = 1'b1; eidx[k] = i;
                        end
                    end
                end
                if (clr) begin
                    for (int i = 0; i < 8; i++) stg[k][i] = 16'h0000;
                    nw[k] = 0; mov[k] = 1'b0; mlk[k] = 1'b0;
                end else if (!mlk[k]) begin
                    if (wr_en) begin
                        full = (nw[k] >= mk[k]);
                        if (full) mov[k] = 1'b1;
                        if (!full || wp[k] != 0) begin
                            stg[k][nw[k] % mk[k]] = din & m;
                            nw[k]++;
                        end
                    end
                    cnt = (nw[k] < mk[k]) ? nw[k] : mk[k];
                    if (kset && cnt > 0) begin
                        for (int i = 0; i < mk[k]; i++) begin
                            key[k][i] = stg[k][i];
                            kv[k][i]  = (i < cnt);
                        end
                        mlk[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_inst(input int k, input logic [3:0] num, input logic [127:0] ka,
                              input logic [7:0] kva, input logic lka, input logic ova,
                              input logic hva, input logic hita, input logic [2:0] idxa);
        logic [127:0] ek;
        logic [7:0]   ekv;
        int cnt;
        ek = 128'd0; ekv = 8'd0;
        for (int i = 0; i < mk[k]; i++) begin
            ek  = ek | (128'(key[k][i]) << (i * kw[k]));
            ekv[i] = kv[k][i];
        end
        cnt = (nw[k] < mk[k]) ? nw[k] : mk[k];
        chk("num_keys",   k, 128'(num),  128'(cnt));
        chk("keys",       k, ka,         ek);
        chk("keys_valid", k, 128'(kva),  128'(ekv));
        chk("locked",     k, 128'(lka),  128'(mlk[k]));
        chk("ovf",        k, 128'(ova),  128'(mov[k]));
        chk("hit_vld",    k, 128'(hva),  128'(ehv[k]));
        if (ehv[k]) begin
            chk("hit",     k, 128'(hita), 128'(ehit[k]));
            chk("hit_idx", k, 128'(idxa), 128'(eidx[k]));
        end
    endtask

    // Every-cycle comparison of all three instances against the model.
    always @(negedge dclk) begin
        if (chk_en) begin
            check_inst(0, {1'b0, num0}, 128'(keys0), {4'd0, kv0}, lk0, ov0, hv0, hit0, {1'b0, hidx0});
            check_inst(1, {1'b0, num1}, 128'(keys1), {4'd0, kv1}, lk1, ov1, hv1, hit1, {1'b0, hidx1});
            check_inst(2, num2, keys2, kv2, lk2, ov2, hv2, hit2, hidx2);
        end
    end

    task automatic cyc(input bit r, input bit w, input logic [15:0] d, input bit ks,
                       input bit c, input bit qv, input logic [15:0] qd);
        reset = r; wr_en = w; din = d; kset = ks; clr = c; q_valid = qv; q_data = qd;
        @(posedge dclk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [15:0] d);
        cyc(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        logic [15:0] d, q;
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_en = 1'b1;
        chk("reset num_keys", 0, 128'(num0), 128'd0);
        chk("reset locked",   0, 128'(lk0),  128'd0);

        wr(16'h0002); wr(16'h0006); wr(16'h000E); wr(16'h001E);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("commit keys",   0, 128'(keys0), 128'h1E0E0602);
        chk("commit kvalid", 0, 128'(kv0),   128'hF);
        chk("commit num",    0, 128'(num0),  128'd4);
        chk("commit locked", 0, 128'(lk0),   128'd1);
        chk("commit ovf",    0, 128'(ov0),   128'd0);

        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h000E);
        chk("lookup 0E vld", 0, 128'(hv0),   128'd1);
        chk("lookup 0E hit", 0, 128'(hit0),  128'd1);
        chk("lookup 0E idx", 0, 128'(hidx0), 128'd2);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0055);
        chk("lookup 55 hit", 0, 128'(hit0),  128'd0);
        chk("lookup 55 idx", 0, 128'(hidx0), 128'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002);
        chk("b2b first idx", 0, 128'(hidx0), 128'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h001E);
        chk("b2b second vld", 0, 128'(hv0),   128'd1);
        chk("b2b second idx", 0, 128'(hidx0), 128'd3);
        idle();
        chk("lookup idle vld", 0, 128'(hv0), 128'd0);

        cyc(1'b0, 1'b1, 16'h003E, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("locked keys", 0, 128'(keys0), 128'h1E0E0602);
        chk("locked ovf",  0, 128'(ov0),   128'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("clr locked", 0, 128'(lk0),   128'd0);
        chk("clr keys",   0, 128'(keys0), 128'h1E0E0602);

        wr(16'h0002); wr(16'h0006); wr(16'h000E); wr(16'h001E); wr(16'h003E);
        chk("full ovf w0", 0, 128'(ov0),  128'd1);
        chk("full ovf w1", 1, 128'(ov1),  128'd1);
        chk("full num w0", 0, 128'(num0), 128'd4);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("drop keys", 0, 128'(keys0), 128'h1E0E0602);
        chk("wrap keys", 1, 128'(keys1), 128'h1E0E063E);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("wrap clr ovf",  1, 128'(ov1),   128'd0);
        chk("wrap clr keys", 1, 128'(keys1), 128'h1E0E063E);
        cyc(1'b0, 1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("wr+kset keys", 0, 128'(keys0), 128'h000000AA);
        chk("wr+kset kv",   0, 128'(kv0),   128'h1);

        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        wr(16'h1234); wr(16'h5678);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("rst num",  2, 128'(num2),  128'd0);
        chk("rst keys", 2, keys2,       128'd0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("empty kset locked", 2, 128'(lk2), 128'd0);

        for (int n = 0; n < 3000; n++) begin
            d = 16'($urandom_range(0, 15));
            q = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) d[15:8] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) q = d;
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 55, d,
                $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 5,
                $urandom_range(0, 99) < 60, q);
        end
        idle();
        @(negedge dclk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_bank.md
Name: key_bank

Overview:
Parametrised key store, successor to the fixed 4 x 8-bit key register. Keys are written one per strobe into a staging bank. A commit strobe atomically copies the staging bank to the published key set. A registered lookup port reports whether a query byte matches any committed key. The block sits between the host byte interface (dclk domain) and the downstream key-compare/decode logic.

Parameters:
KEY_W, 8, width of one key in bits
MAX_KEYS, 4, number of key slots (>=1)
WRAP, 0, 0 = drop writes when full; 1 = overwrite the oldest slot when full
CNT_W, $clog2(MAX_KEYS+1), width of the count outputs (derived; do not override)

Ports:
dclk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
din  in  KEY_W  key data to write
wr_en  in  1  write din into the next staging slot this cycle
kset  in  1  commit the staging bank to the published key set
clr  in  1  clear the staging bank and unlock
q_valid  in  1  lookup request strobe
q_data  in  KEY_W  lookup query
num_keys  out  CNT_W  number of keys in the staging bank
keys  out  MAX_KEYS*KEY_W  committed keys; slot i = keys[i*KEY_W +: KEY_W]
keys_valid  out  MAX_KEYS  per-slot valid bit for the committed set
locked  out  1  1 = committed and not accepting writes
ovf  out  1  sticky; a write arrived while staging was full
hit  out  1  registered lookup result
hit_idx  out  $clog2(MAX_KEYS) (min 1)  lowest matching slot index
hit_vld  out  1  hit/hit_idx qualify; high 1 cycle after q_valid

Behaviour:
- Reset (sync, reset=1 at edge): staging, keys, keys_valid, num_keys, wr_ptr, ovf, hit, hit_idx, hit_vld = 0; state=LOAD; locked=0. Reset overrides every other input.
- States: LOAD (locked=0), LOCKED (locked=1).
- LOAD, wr_en=1 with num_keys<MAX_KEYS: staging[wr_ptr]<=din; wr_ptr++; num_keys++.
- LOAD, wr_en=1 and full, WRAP=0: write dropped; ovf<=1; no other change.
- LOAD, wr_en=1 and full, WRAP=1: staging[wr_ptr]<=din; wr_ptr wraps modulo MAX_KEYS; num_keys stays MAX_KEYS; ovf<=1.
- LOAD, kset=1 with num_keys>0 (after applying a same-cycle write): keys<=staging including the same-cycle din; keys_valid[i]=(i<num_keys_next); state->LOCKED. Outputs are visible the cycle after the edge.
- LOAD, kset=1 with num_keys==0 and no same-cycle write: ignored.
- LOCKED: wr_en and kset are ignored (ovf is not set). keys and keys_valid hold.
- clr=1 in either state: staging, num_keys, wr_ptr, ovf <= 0; state->LOAD. Committed keys and keys_valid are retained, so lookups continue uninterrupted.
- clr has priority over kset and wr_en in the same cycle.
- Lookup:
  - q_valid at edge N gives hit_vld=1 at edge N+1.
  - hit=1 if any slot i has keys_valid[i] and keys slot i == q_data.
  - hit_idx = lowest such i; hit_idx=0 when hit=0.
  - Back-to-back q_valid is supported, one result per cycle.
  - A query in the same cycle as a commit compares against the pre-commit set.
- num_keys saturates at MAX_KEYS and never wraps.
- wr_ptr width is $clog2(MAX_KEYS) (min 1). It wraps to 0 after MAX_KEYS-1.

Decomposition:
- Package key_bank_pkg holds:
  - the state enum (LOAD, LOCKED)
  - the function clog2_min1
  - the slot-extract helper
- Sub-module key_match (KEY_W, MAX_KEYS) contains the registered comparator plus priority encoder for q_data against keys/keys_valid. Instantiate it once.

Test Plan:
1. Defaults: reset, write 0x02, 0x06, 0x0E, 0x1E, then kset -> num_keys=4, keys=0x1E0E0602, keys_valid=4'b1111, locked=1, ovf=0.
2. WRAP=0: write 0x02, 0x06, 0x0E, 0x1E, then 0x3E -> 0x3E dropped, ovf=1, num_keys=4; after kset keys=0x1E0E0602.
3. WRAP=1: same five writes then kset -> keys=0x1E0E063E, ovf=1. Then clr -> ovf=0, locked=0, keys unchanged.
4. Locked: after test 1, write 0x3E and kset -> keys unchanged, num_keys=4, ovf=0. Then clr, write 0xAA with kset in the same cycle -> keys slot0=0xAA, keys_valid=4'b0001.
5. Lookup: after test 1, q_data=0x0E -> next cycle hit_vld=1, hit=1, hit_idx=2; q_data=0x55 -> hit=0, hit_idx=0; back-to-back queries give results on consecutive cycles.
6. Reset mid-operation: after two writes assert reset for 1 cycle -> num_keys=0, keys=0, locked=0. A kset with no writes is ignored (locked stays 0). Repeat with KEY_W=16, MAX_KEYS=8.
